// File: rtl/cnn_layer_sequencer_if.sv
// Handshake bundle between the CNN layer sequencer (master) and the conv/pool/FC datapath (slave).
interface cnn_layer_sequencer_if #(
  parameter int CONV_IMAGE_SIZE = 26,
  parameter int CLASSIFICATIONS = 10,
  parameter int FC_RESULT_DEPTH = 30
);
  localparam int COORD_W = $clog2(CONV_IMAGE_SIZE);
  localparam int CLS_W   = $clog2(CLASSIFICATIONS);

  logic                              start;
  logic                              conv_win_valid;
  logic                              conv_win_ready;
  logic [COORD_W-1:0]                conv_row;
  logic [COORD_W-1:0]                conv_col;
  logic                              conv_last;
  logic                              conv_done;
  logic                              pool_start;
  logic                              pool_done;
  logic                              fc_req;
  logic [CLS_W-1:0]                  fc_class;
  logic                              fc_ack;
  logic signed [FC_RESULT_DEPTH-1:0] fc_result;
  logic [CLASSIFICATIONS-1:0]        led;
  logic                              done;
  logic [2:0]                        state;
  logic                              fault;

  modport master (
    input  start, conv_win_ready, conv_done, pool_done, fc_ack, fc_result,
    output conv_win_valid, conv_row, conv_col, conv_last, pool_start,
           fc_req, fc_class, led, done, state, fault
  );

  modport slave (
    output start, conv_win_ready, conv_done, pool_done, fc_ack, fc_result,
    input  conv_win_valid, conv_row, conv_col, conv_last, pool_start,
           fc_req, fc_class, led, done, state, fault
  );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Top-level CNN inference sequencer: conv window walk, pool trigger, per-class FC query with signed argmax.
// Optional watchdog enabled by defining CNN_SEQ_WATCHDOG_EN (default build: no watchdog, fault tied low).
//
//   state | meaning
//   IDLE  | waiting for start after reset
//   CONV  | streaming window coordinates, then waiting for conv_done
//   POOL  | pool_start pulsed, waiting for pool_done
//   FC    | requesting one result per class, tracking best
//   DONE  | led/done hold the winning class until the next start
//   FAULT | watchdog expired; only start or reset leaves
module cnn_layer_sequencer #(
  parameter int CONV_IMAGE_SIZE = 26,
  parameter int CLASSIFICATIONS = 10,
  parameter int FC_RESULT_DEPTH = 30,
  parameter int WDOG_CYCLES     = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  cnn_layer_sequencer_if.master seq_if
);
  localparam int COORD_W = $clog2(CONV_IMAGE_SIZE);
  localparam int CLS_W   = $clog2(CLASSIFICATIONS);
  localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(CONV_IMAGE_SIZE - 1);
  localparam logic [CLS_W-1:0]   CLS_LAST  = CLS_W'(CLASSIFICATIONS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CONV  = 3'd1,
    S_POOL  = 3'd2,
    S_FC    = 3'd3,
    S_DONE  = 3'd5,
    S_FAULT = 3'd6
  } state_t;

  state_t                            state_q;
  logic [COORD_W-1:0]                row_q, col_q;
  logic                              valid_q, last_q;
  logic                              pool_start_q;
  logic                              fc_req_q;
  logic [CLS_W-1:0]                  fc_class_q;
  logic signed [FC_RESULT_DEPTH-1:0] best_q;
  logic [CLS_W-1:0]                  best_idx_q;
  logic [CLASSIFICATIONS-1:0]        led_q;
  logic                              done_q;
  logic                              fault_q;

  logic [COORD_W-1:0]         row_d, col_d;
  logic                       last_d;
  logic                       xfer, ack, take;
  logic [CLS_W-1:0]           best_idx_d;
  logic [CLASSIFICATIONS-1:0] led_d;
  logic                       wd_hit;

  always_comb begin
    col_d      = (col_q == COORD_MAX) ? '0 : col_q + 1'b1;
    row_d      = (col_q == COORD_MAX) ? row_q + 1'b1 : row_q;
    last_d     = (row_d == COORD_MAX) && (col_d == COORD_MAX);
    xfer       = valid_q && seq_if.conv_win_ready;
    ack        = fc_req_q && seq_if.fc_ack;
    // class 0 seeds the running max; strict compare keeps the lowest index on ties
    take       = (fc_class_q == '0) || (seq_if.fc_result > best_q);
    best_idx_d = take ? fc_class_q : best_idx_q;
    led_d      = CLASSIFICATIONS'(1) << best_idx_d;
  end

`ifdef CNN_SEQ_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'(WDOG_CYCLES - 1);

  logic [WD_W-1:0] wdog_q;
  logic            waiting;

  always_comb begin
    waiting = 1'b0;
    case (state_q)
      S_CONV:  waiting = valid_q ? !seq_if.conv_win_ready : !seq_if.conv_done;
      S_POOL:  waiting = !seq_if.pool_done;
      S_FC:    waiting = fc_req_q && !seq_if.fc_ack;
      default: waiting = 1'b0;
    endcase
    wd_hit = waiting && (wdog_q == '0);
  end

  // any non-waiting cycle (wait entry, transfer, ack) reloads the down-counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q <= WD_LOAD;
    end else if (!waiting) begin
      wdog_q <= WD_LOAD;
    end else if (wdog_q != '0) begin
      wdog_q <= wdog_q - 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      col_q        <= '0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      pool_start_q <= 1'b0;
      fc_req_q     <= 1'b0;
      fc_class_q   <= '0;
      best_q       <= '0;
      best_idx_q   <= '0;
      led_q        <= '0;
      done_q       <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      pool_start_q <= 1'b0;
      if (wd_hit) begin
        state_q  <= S_FAULT;
        fault_q  <= 1'b1;
        valid_q  <= 1'b0;
        fc_req_q <= 1'b0;
        led_q    <= '0;
        done_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_FAULT: begin
            if (seq_if.start) begin
              state_q <= S_CONV;
              row_q   <= '0;
              col_q   <= '0;
              valid_q <= 1'b1;
              last_q  <= (CONV_IMAGE_SIZE == 1);
              led_q   <= '0;
              done_q  <= 1'b0;
              fault_q <= 1'b0;
            end
          end
          S_CONV: begin
            if (xfer) begin
              if (last_q) begin
                valid_q <= 1'b0;
              end else begin
                row_q  <= row_d;
                col_q  <= col_d;
                last_q <= last_d;
              end
            end else if (!valid_q && seq_if.conv_done) begin
              state_q      <= S_POOL;
              pool_start_q <= 1'b1;
            end
          end
          S_POOL: begin
            if (seq_if.pool_done) begin
              state_q    <= S_FC;
              fc_class_q <= '0;
              fc_req_q   <= 1'b1;
            end
          end
          S_FC: begin
            if (ack) begin
              if (take) begin
                best_q     <= seq_if.fc_result;
                best_idx_q <= fc_class_q;
              end
              if (fc_class_q == CLS_LAST) begin
                fc_req_q <= 1'b0;
                state_q  <= S_DONE;
                led_q    <= led_d;
                done_q   <= 1'b1;
              end else begin
                fc_class_q <= fc_class_q + 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign seq_if.conv_win_valid = valid_q;
  assign seq_if.conv_row       = row_q;
  assign seq_if.conv_col       = col_q;
  assign seq_if.conv_last      = last_q;
  assign seq_if.pool_start     = pool_start_q;
  assign seq_if.fc_req         = fc_req_q;
  assign seq_if.fc_class       = fc_class_q;
  assign seq_if.led            = led_q;
  assign seq_if.done           = done_q;
  assign seq_if.state          = state_q;
  assign seq_if.fault          = fault_q;
endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Scoreboard bench for cnn_layer_sequencer: expected window coordinates and winning led are queued at stimulus time.
module tb_cnn_layer_sequencer;
  localparam int SZ   = 26;
  localparam int NCLS = 10;
  localparam int RW   = 30;
  localparam int WD   = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cnn_layer_sequencer_if #(.CONV_IMAGE_SIZE(SZ), .CLASSIFICATIONS(NCLS), .FC_RESULT_DEPTH(RW)) sif ();

  cnn_layer_sequencer #(
    .CONV_IMAGE_SIZE(SZ), .CLASSIFICATIONS(NCLS), .FC_RESULT_DEPTH(RW), .WDOG_CYCLES(WD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .seq_if(sif)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int pool_cnt = 0;
  bit stall_en = 1'b0;
  int stall_cnt = 0;
  logic [15:0]         exp_coord_q[$];
  logic [NCLS-1:0]     exp_led_q[$];
  logic signed [RW-1:0] res_tbl [NCLS];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // peer models: ready with optional stall at (3,4), zero-wait FC responder
  always @(posedge clk) begin
    #1;
    if (!stall_en) stall_cnt = 0;
    if (stall_en && sif.conv_win_valid && sif.conv_row == 5'd3 && sif.conv_col == 5'd4 && stall_cnt < 5) begin
      sif.conv_win_ready = 1'b0;
      stall_cnt++;
    end else begin
      sif.conv_win_ready = 1'b1;
    end
    sif.fc_ack = sif.fc_req;
    sif.fc_result = (sif.fc_class < NCLS) ? res_tbl[sif.fc_class] : '0;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (sif.pool_start) pool_cnt++;
      if (sif.conv_win_valid && sif.conv_win_ready) begin
        if (exp_coord_q.size() == 0) check_eq("conv_unexpected_xfer", 1, 0);
        else check_eq("conv_coord", {sif.conv_last, sif.conv_row, sif.conv_col}, exp_coord_q.pop_front());
      end
      if (stall_en && sif.conv_win_valid && !sif.conv_win_ready)
        check_eq("stall_hold", {sif.conv_win_valid, sif.conv_row, sif.conv_col}, {1'b1, 5'd3, 5'd4});
    end
  end

  task automatic push_coords();
    for (int r = 0; r < SZ; r++) begin
      for (int c = 0; c < SZ; c++) begin
        logic [4:0] rr;
        logic [4:0] cc;
        logic       ll;
        rr = 5'(r);
        cc = 5'(c);
        ll = (r == SZ - 1) && (c == SZ - 1);
        exp_coord_q.push_back({5'd0, ll, rr, cc});
      end
    end
  endtask

  task automatic push_led();
    logic signed [RW-1:0] best;
    int bi;
    logic [NCLS-1:0] one;
    best = res_tbl[0];
    bi = 0;
    for (int i = 1; i < NCLS; i++) begin
      if (res_tbl[i] > best) begin
        best = res_tbl[i];
        bi = i;
      end
    end
    one = '0;
    one[bi] = 1'b1;
    exp_led_q.push_back(one);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 sif.start = 1'b1;
    @(posedge clk); #1 sif.start = 1'b0;
  endtask

  task automatic drain_conv();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (exp_coord_q.size() == 0 && !sif.conv_win_valid) ok = 1'b1;
    end
    check_eq("conv_drain_timeout", ok, 1);
    @(posedge clk); #1 sif.conv_done = 1'b1;
    @(posedge clk); #1 sif.conv_done = 1'b0;
  endtask

  task automatic run_inference(input bit early_done);
    bit ok;
    int p0;
    p0 = pool_cnt;
    push_coords();
    push_led();
    pulse_start();
    if (early_done) begin
      sif.conv_done = 1'b1;
      @(posedge clk); #1 sif.conv_done = 1'b0;
    end
    drain_conv();
    repeat (3) @(posedge clk);
    #1 sif.pool_done = 1'b1;
    @(posedge clk); #1 sif.pool_done = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (sif.done) ok = 1'b1;
    end
    check_eq("done_timeout", ok, 1);
    check_eq("led", sif.led, exp_led_q.pop_front());
    check_eq("done_state", sif.state, 3'd5);
    check_eq("pool_start_pulses", pool_cnt - p0, 1);
    check_eq("fault_low", sif.fault, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    exp_coord_q.delete();
    #1 rst_n = 1'b1;
  endtask

  initial begin
    bit ok;
    sif.start = 1'b0;
    sif.conv_win_ready = 1'b1;
    sif.conv_done = 1'b0;
    sif.pool_done = 1'b0;
    sif.fc_ack = 1'b0;
    sif.fc_result = '0;
    for (int i = 0; i < NCLS; i++) res_tbl[i] = -30'sd5;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_state", sif.state, 0);
    check_eq("reset_outputs", {sif.led, sif.done, sif.conv_win_valid, sif.fault, sif.pool_start, sif.fc_req}, 0);
    rst_n = 1'b1;

    // class 7 wins
    res_tbl[7] = 30'sd1000;
    run_inference(1'b0);

    // backpressure at (3,4) plus a premature conv_done that must be ignored
    for (int i = 0; i < NCLS; i++) res_tbl[i] = -30'sd3;
    stall_en = 1'b1;
    run_inference(1'b1);
    stall_en = 1'b0;

    for (int i = 0; i < NCLS; i++) res_tbl[i] = 30'sd0;
    res_tbl[2] = 30'sd500;
    res_tbl[6] = 30'sd500;
    run_inference(1'b0);

    res_tbl[9] = 30'sd501;
    res_tbl[0] = -30'sd100000;
    run_inference(1'b0);

    // async reset mid-window
    push_coords();
    pulse_start();
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(negedge clk);
      if (sif.conv_row == 5'd10 && sif.conv_col == 5'd10) ok = 1'b1;
    end
    check_eq("reach_10_10_timeout", ok, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_rst_state", sif.state, 0);
    check_eq("async_rst_outputs", {sif.led, sif.done, sif.conv_win_valid, sif.fault}, 0);
    repeat (2) @(posedge clk);
    exp_coord_q.delete();
    #1 rst_n = 1'b1;
    run_inference(1'b0);

    // pool_done withheld
    push_coords();
    pulse_start();
    drain_conv();
`ifdef CNN_SEQ_WATCHDOG_EN
    repeat (WD - 1) @(posedge clk);
    #1 check_eq("wdog_pre_expiry", sif.state, 2);
    @(posedge clk);
    #1;
    check_eq("wdog_state", sif.state, 6);
    check_eq("wdog_outputs", {sif.fault, sif.conv_win_valid, sif.fc_req, sif.done, sif.led}, {1'b1, 13'd0});
    push_coords();
    sif.start = 1'b1;
    @(posedge clk); #1 sif.start = 1'b0;
    check_eq("fault_exit_state", sif.state, 1);
    check_eq("fault_exit_flag", sif.fault, 0);
`else
    repeat (40) @(posedge clk);
    #1;
    check_eq("no_wdog_state", sif.state, 2);
    check_eq("no_wdog_fault", sif.fault, 0);
`endif
    do_reset();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
